// File: rtl/commit_trace_buffer_if.sv
// Commit/pop bus for the commit trace buffer.
// The core side is the master: it drives commits and pop requests.
interface commit_trace_buffer_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int SEQ_W  = 16
);
  logic              commit_valid;
  logic [PC_W-1:0]   commit_pc;
  logic [INST_W-1:0] commit_inst;
  logic              commit_rf_we;
  logic [REG_AW-1:0] commit_rf_addr;
  logic [DATA_W-1:0] commit_rf_wdata;
  logic              rd_en;
  logic              rd_valid;
  logic [PC_W-1:0]   rd_pc;
  logic [INST_W-1:0] rd_inst;
  logic              rd_rf_we;
  logic [REG_AW-1:0] rd_rf_addr;
  logic [DATA_W-1:0] rd_rf_wdata;
  logic [SEQ_W-1:0]  rd_seq;

  modport master (
    output commit_valid, commit_pc, commit_inst,
    output commit_rf_we, commit_rf_addr, commit_rf_wdata,
    output rd_en,
    input  rd_valid, rd_pc, rd_inst,
    input  rd_rf_we, rd_rf_addr, rd_rf_wdata, rd_seq
  );

  modport slave (
    input  commit_valid, commit_pc, commit_inst,
    input  commit_rf_we, commit_rf_addr, commit_rf_wdata,
    input  rd_en,
    output rd_valid, rd_pc, rd_inst,
    output rd_rf_we, rd_rf_addr, rd_rf_wdata, rd_seq
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit trace capture: circular buffer of committed instructions.
// Optional TRACE_RFONLY_FILTER_EN keeps only commits writing a nonzero reg.
module commit_trace_buffer #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 16,
  parameter int SEQ_W  = 16
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   trig_en,
  input  logic [PC_W-1:0]        trig_pc,
  input  logic                   wrap_mode,
`ifdef TRACE_RFONLY_FILTER_EN
  input  logic                   filt_rf_only,
`endif
  commit_trace_buffer_if.slave   bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic [1:0]             state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_CAPT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              we;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SEQ_W-1:0]  seq;
  } ent_t;

  ent_t            r_mem [DEPTH];
  ent_t            r_rd;
  logic            r_rd_valid;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_empty;
  logic            r_full;
  logic            r_ovf;
  logic [SEQ_W-1:0] r_seq;

  logic w_hit;
  logic w_accept;
  logic w_filt_ok;
  logic w_store;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_fill;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (arm) begin
      w_state_nxt = S_ARMED;
    end else begin
      unique case (r_state)
        S_ARMED: if (!trig_en || w_hit) w_state_nxt = S_CAPT;
        S_CAPT:  if (stop || (!wrap_mode && w_fill)) w_state_nxt = S_DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // The trigger commit itself is accepted while still in ARMED.
  always_comb begin
    w_hit    = bus.commit_valid && (bus.commit_pc == trig_pc);
    w_accept = !arm && bus.commit_valid &&
               ((r_state == S_CAPT) ||
                ((r_state == S_ARMED) && trig_en && w_hit));
`ifdef TRACE_RFONLY_FILTER_EN
    w_filt_ok = !filt_rf_only ||
                (bus.commit_rf_we && (bus.commit_rf_addr != '0));
`else
    w_filt_ok = 1'b1;
`endif
    w_store = w_accept && w_filt_ok;
    w_pop   = bus.rd_en && !r_empty;
    w_push  = w_store && (!r_full || wrap_mode || w_pop);
    w_drop  = w_push && r_full && !w_pop;
    w_fill  = w_push && !w_pop && (r_count == CW'(DEPTH - 1));
    unique case ({w_push && !w_drop, w_pop})
      2'b10:   w_cnt_nxt = r_count + 1'b1;
      2'b01:   w_cnt_nxt = r_count - 1'b1;
      default: w_cnt_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{
        pc:    bus.commit_pc,
        inst:  bus.commit_inst,
        we:    bus.commit_rf_we,
        addr:  bus.commit_rf_addr,
        wdata: bus.commit_rf_wdata,
        seq:   r_seq
      };
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_rd       <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) r_rd <= r_mem[r_rptr];
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_seq   <= '0;
    end else if (arm) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_seq   <= '0;
    end else begin
      if (w_push)          r_wptr <= r_wptr + 1'b1;
      if (w_pop || w_drop) r_rptr <= r_rptr + 1'b1;
      if (w_accept)        r_seq  <= r_seq + 1'b1;
      if (w_drop)          r_ovf  <= 1'b1;
      r_count <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
    end
  end

  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_pc       = r_rd.pc;
  assign bus.rd_inst     = r_rd.inst;
  assign bus.rd_rf_we    = r_rd.we;
  assign bus.rd_rf_addr  = r_rd.addr;
  assign bus.rd_rf_wdata = r_rd.wdata;
  assign bus.rd_seq      = r_rd.seq;
  assign count           = r_count;
  assign empty           = r_empty;
  assign full            = r_full;
  assign overflow        = r_ovf;
  assign state           = r_state;
endmodule
